mul_unit: RTL and testbench

Iterative multi-cycle multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It sits in the execute stage, directly downstream of the decoder's control logic, and consumes the 3-bit `mulsel` code that the decoder produces. It drives a stall request back to the hazard logic while it works. It returns the selected 32-bit half of the 64-bit product with a one-cycle `done` pulse.

---
 rtl/mul_unit.sv | 116 +++++++++++
 tb/tb_mul_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Iterative radix-2 multiplier for RV32M MUL/MULH/MULHSU/MULHU; stalls EX while busy.
// Define MUL_ZERO_SKIP_EN to finish zero-operand ops without the shift-add loop.
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            start,
    input  logic [2:0]      mulsel,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'b001;
    localparam logic [2:0] OP_MULH   = 3'b010;
    localparam logic [2:0] OP_MULHSU = 3'b011;
    localparam logic [2:0] OP_MULHU  = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] res_q;

    logic        valid_op;
    logic        accept;
    logic        zero_op;
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [31:0] prod_sel;

    assign valid_op = (mulsel == OP_MUL) | (mulsel == OP_MULH) |
                      (mulsel == OP_MULHSU) | (mulsel == OP_MULHU);
    assign accept   = (state == IDLE) & start & valid_op & ~flush & ~Rst;

    assign a_sgn = ((mulsel == OP_MULH) | (mulsel == OP_MULHSU)) & rs1_data[31];
    assign b_sgn = (mulsel == OP_MULH) & rs2_data[31];
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign mag_a = a_sgn ? (~rs1_data + 32'd1) : rs1_data;
    assign mag_b = b_sgn ? (~rs2_data + 32'd1) : rs2_data;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (rs1_data == 32'd0) | (rs2_data == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    assign prod     = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign prod_sel = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

    assign busy   = (state == BUSY) | accept;
    assign done   = (state == DONE) & ~flush;
    assign result = done ? prod_sel : res_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = zero_op ? DONE : BUSY;
            BUSY: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt_q == 6'd1)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            res_q    <= 32'd0;
        end else if (accept) begin
            op_q     <= mulsel;
            neg_q    <= a_sgn ^ b_sgn;
            cnt_q    <= 6'd32;
            acc_q    <= 64'd0;
            mcand_q  <= {32'd0, mag_a};
            mplier_q <= mag_b;
        end else if (state == BUSY && !flush) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 6'd1;
        end else if (done) begin
            res_q <= prod_sel;
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Randomized self-checking bench for mul_unit against a 64-bit arithmetic model.
// Honours MUL_ZERO_SKIP_EN when computing expected latency.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [2:0]  mulsel;
    logic        flush;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_exp;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    always #5 clk = ~clk;

    mul_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .Rst     (Rst),
        .start   (start),
        .mulsel  (mulsel),
        .flush   (flush),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (sel)
            3'd1:    p = ua * ub;
            3'd2:    p = sa * sb;
            3'd3:    p = sa * ub;
            3'd4:    p = ua * ub;
            default: p = 64'd0;
        endcase
        return (sel == 3'd1) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input string tag, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit noise);
        int lat, bcnt, got_cyc;
        logic [31:0] res_seen;
        lat = (ZSKIP && (a == 0 || b == 0)) ? 1 : 33;
        res_seen = 32'hdead_beef;
        @(negedge clk);
        start = 1'b1; mulsel = sel; rs1_data = a; rs2_data = b;
        #1;
        check({tag, "/busy0"}, 32'(busy), 32'd1);
        bcnt = 1;
        got_cyc = -1;
        for (int k = 1; k <= 40 && got_cyc < 0; k++) begin
            @(negedge clk);
            if (noise) begin
                start    = 1'b1;
                mulsel   = 3'($urandom_range(1, 4));
                rs1_data = $urandom;
                rs2_data = $urandom;
            end else begin
                start  = 1'b0;
                mulsel = 3'd0;
            end
            #1;
            if (busy) bcnt++;
            if (done) begin
                got_cyc  = k;
                res_seen = result;
                start    = 1'b0;
                mulsel   = 3'd0;
            end
        end
        check({tag, "/lat"}, 32'(got_cyc), 32'(lat));
        check({tag, "/res"}, res_seen, exp);
        check({tag, "/busycyc"}, 32'(bcnt), 32'(lat));
        @(negedge clk);
        #1;
        check({tag, "/done_off"}, 32'(done), 32'd0);
        check({tag, "/hold"}, result, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [2:0]  sel;
        logic [31:0] a, b;
        logic [2:0]  bad [4];
        bad[0] = 3'd0; bad[1] = 3'd5; bad[2] = 3'd6; bad[3] = 3'd7;

        Rst = 1'b0; start = 1'b0; mulsel = 3'd0; flush = 1'b0;
        rs1_data = 32'd0; rs2_data = 32'd0;
        #2 Rst = 1'b1;
        #1;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/res", result, 32'd0);
        repeat (2) @(negedge clk);
        Rst = 1'b0;
        last_exp = 32'd0;

        run_op("mul7x-3", 3'd1, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0);
        run_op("mulhu_min", 3'd4, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulh_m1x2", 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_m1x2", 3'd4, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0);
        run_op("zero_a", 3'd1, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
        run_op("mulhsu_noise", 3'd3, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 1'b1);

        // flush at cycle 10, new op accepted at cycle 12
        @(negedge clk);
        start = 1'b1; mulsel = 3'd1; rs1_data = 32'd5; rs2_data = 32'd7;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0; mulsel = 3'd0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush/done10", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush/busy11", 32'(busy), 32'd0);
        check("flush/done11", 32'(done), 32'd0);
        check("flush/res11", result, last_exp);
        run_op("post_flush", 3'd1, 32'd1234, 32'd5678, 32'd7006652, 1'b0);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; mulsel = 3'd2; rs1_data = 32'd3; rs2_data = 32'd9;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0; mulsel = 3'd0;
        end
        #2 Rst = 1'b1;
        #1;
        check("arst/busy", 32'(busy), 32'd0);
        check("arst/done", 32'(done), 32'd0);
        check("arst/res", result, 32'd0);
        @(negedge clk);
        Rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            check("arst/idle_busy", 32'(busy), 32'd0);
            check("arst/idle_done", 32'(done), 32'd0);
        end
        run_op("post_rst", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);

        // invalid op codes never start the unit
        foreach (bad[i]) begin
            @(negedge clk);
            start = 1'b1; mulsel = bad[i];
            rs1_data = $urandom; rs2_data = $urandom;
            for (int k = 0; k < 3; k++) begin
                #1;
                check("badop/busy", 32'(busy), 32'd0);
                check("badop/done", 32'(done), 32'd0);
                @(negedge clk);
            end
            start = 1'b0; mulsel = 3'd0;
        end

        repeat (40) begin
            sel = 3'($urandom_range(1, 4));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                3: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'd1;
                default: b = $urandom;
            endcase
            run_op("rnd", sel, a, b, ref_mul(sel, a, b), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
